// File: rtl/tick_gen.sv
// Multi-channel programmable divider: each channel counts clk edges up to a
// runtime-loadable terminal count and emits a one-cycle tick plus either a
// 50%-duty divided clock (mode 0) or a one-cycle strobe (mode 1).
// Latency: all outputs registered; period = counts+1 enabled cycles.
// Backpressure: none; en[i] low freezes a channel's counter without losing count.
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         asynchronous active-low reset
//   en          per-channel count enable
//   mode        per-channel output mode (0 = toggle, 1 = pulse)
//   load        single-cycle request to write load_counts into channel load_ch
//   load_ch     target channel of load (values >= CHANNELS are ignored)
//   load_counts new terminal count for the loaded channel
//   sync        restart every channel at once and clear all outputs
//   div_out     per-channel divided clock / strobe
//   tick        per-channel one-cycle pulse at terminal count
module tick_gen #(
    parameter int CHANNELS       = 4,
    parameter int COUNTER_BITS   = 25,
    parameter int DEFAULT_COUNTS = 18750000,
    parameter int CH_BITS        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CHANNELS-1:0]     en,
    input  logic [CHANNELS-1:0]     mode,
    input  logic                    load,
    input  logic [CH_BITS-1:0]      load_ch,
    input  logic [COUNTER_BITS-1:0] load_counts,
    input  logic                    sync,
    output logic [CHANNELS-1:0]     div_out,
    output logic [CHANNELS-1:0]     tick
);

    localparam logic [COUNTER_BITS-1:0] DEF_CNT = COUNTER_BITS'(DEFAULT_COUNTS);

    logic [COUNTER_BITS-1:0] ctr    [CHANNELS];
    logic [COUNTER_BITS-1:0] counts [CHANNELS];
    logic [CHANNELS-1:0]     load_hit;

    // Decode the load target; an out-of-range load_ch matches no channel,
    // so the whole load is dropped.
    always_comb begin
        load_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            load_hit[i] = load && (int'(load_ch) == i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                ctr[i]    <= '0;
                counts[i] <= DEF_CNT;
            end
            div_out <= '0;
            tick    <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                // The period register takes a load even when sync wins the
                // counter/output update in the same cycle.
                if (load_hit[i]) begin
                    counts[i] <= load_counts;
                end

                if (sync) begin
                    ctr[i]     <= '0;
                    div_out[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                end else if (load_hit[i]) begin
                    ctr[i]  <= '0;
                    tick[i] <= 1'b0;
                    if (mode[i]) begin
                        div_out[i] <= 1'b0;
                    end
                end else if (en[i]) begin
                    // >= rather than == so a counter stranded above a freshly
                    // shrunk period wraps at once instead of running to overflow.
                    if (ctr[i] >= counts[i]) begin
                        ctr[i]     <= '0;
                        tick[i]    <= 1'b1;
                        div_out[i] <= mode[i] ? 1'b1 : ~div_out[i];
                    end else begin
                        ctr[i]  <= ctr[i] + 1'b1;
                        tick[i] <= 1'b0;
                        if (mode[i]) begin
                            div_out[i] <= 1'b0;
                        end
                    end
                end else begin
                    tick[i] <= 1'b0;
                    if (mode[i]) begin
                        div_out[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
